ddr4_app_responder: RTL and testbench
=====================================

// Module: ddr4_app_responder
// PURPOSE
//  Synthesizable responder for the DDR4 user (app_*) interface: accepts app commands and write data
//  from a DDR initiator, executes them in order against on-chip memory, returns read data. Sits where the
//  memory-controller IP sits, so the DDR-facing controller and BRAM dataflow run without physical DDR4.
// PARAMETERS
//  ADDR_W 28 app_addr width | DATA_W 576 beat width | MASK_W 72 byte mask width (DATA_W/8)
//  MEM_AW 8 memory index bits (256 words) | ADDR_LSB 3 app_addr bit where word index starts (BL8 step 8)
//  CMD_DEPTH 4 cmd queue entries | WDF_DEPTH 4 write-data queue entries
//  RD_LAT 6 memory-accept to rd_data_valid cycles (>=2) | INIT_CYCLES 16 reset release to calib complete
// PORTS
//  c0_ddr4_ui_clk            in  1       single clock, all logic rising edge
//  c0_ddr4_aresetn           in  1       asynchronous active-low reset
//  c0_init_calib_complete    out 1       high INIT_CYCLES after reset release, then stays high
//  c0_ddr4_app_addr          in  ADDR_W  command address
//  c0_ddr4_app_cmd           in  3       0 write, 1 read, others illegal
//  c0_ddr4_app_en            in  1       command valid
//  c0_ddr4_app_hi_pri        in  1       ignored
//  c0_ddr4_app_rdy           out 1       command accepted when app_en&app_rdy
//  c0_ddr4_app_wdf_data      in  DATA_W  write beat
//  c0_ddr4_app_wdf_mask      in  MASK_W  bit i=1: byte i not written
//  c0_ddr4_app_wdf_wren      in  1       write beat valid
//  c0_ddr4_app_wdf_end       in  1       last beat; must equal wren (single beat per burst)
//  c0_ddr4_app_wdf_rdy       out 1       beat accepted when wren&wdf_rdy
//  c0_ddr4_app_rd_data       out DATA_W  read beat
//  c0_ddr4_app_rd_data_valid out 1       read beat valid, one cycle per read command
//  c0_ddr4_app_rd_data_end   out 1       equals rd_data_valid
//  err_flags                 out 3       sticky: [0] illegal cmd [1] wren!=wdf_end [2] reserved 0
// BEHAVIOUR
//  Reset: all outputs 0; queues, read pipe, init counter cleared. Memory contents NOT reset.
//  Init: counter runs from reset release; app_rdy and wdf_rdy forced 0 until calib complete.
//  app_rdy = calib & cmd queue not full (registered; full counted incl. same-cycle pop: pop frees slot next cycle).
//  wdf_rdy = calib & wdf queue not full, same rule. Write data may arrive before, with, or after its command.
//  Index = app_addr[ADDR_LSB +: MEM_AW]; upper bits ignored (address wraps modulo 2^MEM_AW).
//  Exec FSM, one op per cycle, strict issue order: IDLE -> (queue head read) RD: read memory, push tag into
//  RD_LAT pipe, pop cmd -> IDLE/next; (head write) WR_WAIT until wdf queue non-empty -> WR: masked byte write,
//  pop both queues. Head write with empty wdf queue stalls following reads (no reordering).
//  Read-after-write same index: read issued after write returns new data (memory write-first ordering guaranteed).
//  Illegal cmd: accepted, popped with no memory access, no read data, err_flags[0] set.
//  wren!=wdf_end: beat still taken as a full beat; err_flags[1] set. err_flags cleared only by reset.
//  Read data: rd_data_valid exactly RD_LAT cycles after RD issue; back-to-back reads give back-to-back valids.
//  No rd_data backpressure; initiator must always sink.
//  Mid-operation reset: in-flight reads dropped, no valid emitted after reset asserts; queued writes lost.
// CONFIGURATION
//  DDR4_RESP_BACKPRESSURE_EN defined: 16-bit LFSR (seed 16'hACE1 at reset) gates app_rdy and wdf_rdy
//  independently, each low when its LFSR bit[1:0]==0 (~25%), to stress initiator handshakes.
//  Undefined: rdy depends only on calib and queue occupancy as above.
// STRUCTURE
//  Package ddr4_app_pkg: CMD_WRITE=3'd0, CMD_READ=3'd1, default widths, exec FSM state encoding.
//  Sub-module ddr4_resp_fifo (parameterised sync FIFO, width/depth, full/empty) instanced for cmd
//  ({cmd,index}) and wdf ({mask,data}) queues. Memory and read pipe inline.
// TESTING
//  Reset release -> calib rises cycle 16; app_rdy/wdf_rdy 0 before, 1 after (backpressure undefined).
//  Write addr 0x8 data all-5A mask 0, read addr 0x8 -> one valid with all-5A, RD_LAT after issue.
//  Write all-FF, then all-00 with mask 72'h..FE, read -> byte 0 = 00, bytes 1..71 = FF.
//  Write cmd with no data 10 cycles, then 5 reads queued -> app_rdy drops after 4 queued; beat arrives
//  -> write then reads complete in order, valid count 5.
//  Write addr 0x0 and 0x800 (MEM_AW 8) -> second overwrites first; read 0x0 returns second data.
//  cmd=3'd4 -> accepted, no rd_data_valid, err_flags=3'b001; aresetn low mid-read -> no valid.

Source files
------------

// File: rtl/ddr4_app_pkg.sv
// rtl/ddr4_app_pkg.sv - command codes, default widths and exec FSM encoding for the DDR4 app responder
package ddr4_app_pkg;
  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  localparam int DEF_ADDR_W      = 28;
  localparam int DEF_DATA_W      = 576;
  localparam int DEF_MASK_W      = DEF_DATA_W / 8;
  localparam int DEF_MEM_AW      = 8;
  localparam int DEF_ADDR_LSB    = 3;
  localparam int DEF_CMD_DEPTH   = 4;
  localparam int DEF_WDF_DEPTH   = 4;
  localparam int DEF_RD_LAT      = 6;
  localparam int DEF_INIT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_WR      = 2'd3
  } exec_state_t;
endpackage

// File: rtl/ddr4_resp_fifo.sv
// rtl/ddr4_resp_fifo.sv - small synchronous FIFO with look-ahead head and next-cycle full flag
module ddr4_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          do_push, do_pop;

  assign do_push    = push && (count != CW'(DEPTH));
  assign do_pop     = pop && (count != '0);
  assign count_next = count + CW'(do_push) - CW'(do_pop);
  assign empty      = (count == '0);
  // Full as seen after this edge, so a registered ready never overcommits.
  assign full_next  = (count_next == CW'(DEPTH));
  assign head       = store[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ddr4_app_responder.sv
// rtl/ddr4_app_responder.sv - DDR4 app-interface responder backed by on-chip memory
// Define DDR4_RESP_BACKPRESSURE_EN to gate app_rdy/wdf_rdy with a pseudo-random LFSR.
module ddr4_app_responder
  import ddr4_app_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MASK_W      = DEF_MASK_W,
  parameter int MEM_AW      = DEF_MEM_AW,
  parameter int ADDR_LSB    = DEF_ADDR_LSB,
  parameter int CMD_DEPTH   = DEF_CMD_DEPTH,
  parameter int WDF_DEPTH   = DEF_WDF_DEPTH,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic              c0_ddr4_ui_clk,
  input  logic              c0_ddr4_aresetn,
  output logic              c0_init_calib_complete,
  input  logic [ADDR_W-1:0] c0_ddr4_app_addr,
  input  logic [2:0]        c0_ddr4_app_cmd,
  input  logic              c0_ddr4_app_en,
  input  logic              c0_ddr4_app_hi_pri,
  output logic              c0_ddr4_app_rdy,
  input  logic [DATA_W-1:0] c0_ddr4_app_wdf_data,
  input  logic [MASK_W-1:0] c0_ddr4_app_wdf_mask,
  input  logic              c0_ddr4_app_wdf_wren,
  input  logic              c0_ddr4_app_wdf_end,
  output logic              c0_ddr4_app_wdf_rdy,
  output logic [DATA_W-1:0] c0_ddr4_app_rd_data,
  output logic              c0_ddr4_app_rd_data_valid,
  output logic              c0_ddr4_app_rd_data_end,
  output logic [2:0]        err_flags
);
  localparam int CMD_W = 3 + MEM_AW;
  localparam int WDF_W = MASK_W + DATA_W;
  localparam int IW    = $clog2(INIT_CYCLES + 1);

  logic [IW-1:0]     init_cnt;
  logic              calib_q, calib_d;
  logic              app_rdy_q, wdf_rdy_q, bp_app, bp_wdf;
  logic              cmd_push, cmd_pop, cmd_empty, cmd_full_next;
  logic              wdf_push, wdf_pop, wdf_empty, wdf_full_next;
  logic [CMD_W-1:0]  cmd_head;
  logic [WDF_W-1:0]  wdf_head;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  exec_state_t       state;
  logic [MEM_AW-1:0] ex_idx;
  logic [DATA_W-1:0] ex_data;
  logic [MASK_W-1:0] ex_mask;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] vld_pipe;
  logic [1:0]        err_q;
  logic              unused_bits;

  assign unused_bits = ^{c0_ddr4_app_hi_pri,
                         c0_ddr4_app_addr[ADDR_W-1:ADDR_LSB+MEM_AW],
                         c0_ddr4_app_addr[ADDR_LSB-1:0]};

`ifdef DDR4_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_aresetn) begin
    if (!c0_ddr4_aresetn) lfsr <= 16'hACE1;
    else                  lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  // Widely separated bit pairs keep the two ready gates decorrelated.
  assign bp_app = |lfsr[1:0];
  assign bp_wdf = |lfsr[9:8];
`else
  assign bp_app = 1'b1;
  assign bp_wdf = 1'b1;
`endif

  assign calib_d  = calib_q | (init_cnt == IW'(INIT_CYCLES - 1));
  assign cmd_push = c0_ddr4_app_en & app_rdy_q;
  assign wdf_push = c0_ddr4_app_wdf_wren & wdf_rdy_q;

  always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_aresetn) begin
    if (!c0_ddr4_aresetn) begin
      init_cnt  <= '0;
      calib_q   <= 1'b0;
      app_rdy_q <= 1'b0;
      wdf_rdy_q <= 1'b0;
    end else begin
      if (!calib_q) init_cnt <= init_cnt + IW'(1);
      calib_q   <= calib_d;
      app_rdy_q <= calib_d & ~cmd_full_next & bp_app;
      wdf_rdy_q <= calib_d & ~wdf_full_next & bp_wdf;
    end
  end

  ddr4_resp_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (c0_ddr4_ui_clk),
    .rst_n     (c0_ddr4_aresetn),
    .push      (cmd_push),
    .push_data ({c0_ddr4_app_cmd, c0_ddr4_app_addr[ADDR_LSB +: MEM_AW]}),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .empty     (cmd_empty),
    .full_next (cmd_full_next)
  );

  ddr4_resp_fifo #(.W(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .clk       (c0_ddr4_ui_clk),
    .rst_n     (c0_ddr4_aresetn),
    .push      (wdf_push),
    .push_data ({c0_ddr4_app_wdf_mask, c0_ddr4_app_wdf_data}),
    .pop       (wdf_pop),
    .head      (wdf_head),
    .empty     (wdf_empty),
    .full_next (wdf_full_next)
  );

  assign head_cmd = cmd_head[CMD_W-1:MEM_AW];
  assign head_idx = cmd_head[MEM_AW-1:0];

  // A write at the queue head blocks everything behind it until its beat exists.
  always_comb begin
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    if (!cmd_empty) begin
      if (head_cmd == CMD_WRITE) begin
        cmd_pop = !wdf_empty;
        wdf_pop = !wdf_empty;
      end else begin
        cmd_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_aresetn) begin
    if (!c0_ddr4_aresetn) begin
      state  <= ST_IDLE;
      ex_idx <= '0;
      err_q  <= '0;
    end else begin
      if (cmd_pop) begin
        ex_idx <= head_idx;
        case (head_cmd)
          CMD_WRITE: state <= ST_WR;
          CMD_READ:  state <= ST_RD;
          default: begin
            state    <= ST_IDLE;
            err_q[0] <= 1'b1;
          end
        endcase
      end else begin
        state <= cmd_empty ? ST_IDLE : ST_WR_WAIT;
      end
      if (c0_ddr4_app_wdf_wren != c0_ddr4_app_wdf_end) err_q[1] <= 1'b1;
    end
  end

  always_ff @(posedge c0_ddr4_ui_clk) begin
    if (wdf_pop) begin
      ex_data <= wdf_head[DATA_W-1:0];
      ex_mask <= wdf_head[WDF_W-1:DATA_W];
    end
    if (state == ST_WR) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!ex_mask[b]) mem[ex_idx][8*b +: 8] <= ex_data[8*b +: 8];
      end
    end
  end

  // Memory read lands in stage 0; the last stage is the visible read beat.
  always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_aresetn) begin
    if (!c0_ddr4_aresetn) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-2:0], state == ST_RD};
      if (state == ST_RD) rd_pipe[0] <= mem[ex_idx];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign c0_init_calib_complete    = calib_q;
  assign c0_ddr4_app_rdy           = app_rdy_q;
  assign c0_ddr4_app_wdf_rdy       = wdf_rdy_q;
  assign c0_ddr4_app_rd_data       = rd_pipe[RD_LAT-1];
  assign c0_ddr4_app_rd_data_valid = vld_pipe[RD_LAT-1];
  assign c0_ddr4_app_rd_data_end   = vld_pipe[RD_LAT-1];
  assign err_flags                 = {1'b0, err_q};
endmodule

// File: tb/tb_ddr4_app_responder.sv
// tb/tb_ddr4_app_responder.sv - directed table-driven bench for ddr4_app_responder
module tb_ddr4_app_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         hi_pri = 1'b0;
  logic         app_rdy;
  logic [575:0] wdf_data = '0;
  logic [71:0]  wdf_mask = '0;
  logic         wren = 1'b0;
  logic         wend = 1'b0;
  logic         wdf_rdy;
  logic [575:0] rd_data;
  logic         rd_valid;
  logic         rd_end;
  logic [2:0]   err;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  logic [575:0] last_rd = '0;

  always #5 clk = ~clk;

  ddr4_app_responder dut (
    .c0_ddr4_ui_clk            (clk),
    .c0_ddr4_aresetn           (rst_n),
    .c0_init_calib_complete    (calib),
    .c0_ddr4_app_addr          (app_addr),
    .c0_ddr4_app_cmd           (app_cmd),
    .c0_ddr4_app_en            (app_en),
    .c0_ddr4_app_hi_pri        (hi_pri),
    .c0_ddr4_app_rdy           (app_rdy),
    .c0_ddr4_app_wdf_data      (wdf_data),
    .c0_ddr4_app_wdf_mask      (wdf_mask),
    .c0_ddr4_app_wdf_wren      (wren),
    .c0_ddr4_app_wdf_end       (wend),
    .c0_ddr4_app_wdf_rdy       (wdf_rdy),
    .c0_ddr4_app_rd_data       (rd_data),
    .c0_ddr4_app_rd_data_valid (rd_valid),
    .c0_ddr4_app_rd_data_end   (rd_end),
    .err_flags                 (err)
  );

  always @(negedge clk) begin
    if (rd_valid) begin
      vld_cnt++;
      last_rd = rd_data;
    end
  end

  typedef struct {
    string        nm;
    logic [2:0]   cmd;
    logic [27:0]  addr;
    logic [575:0] data;
    logic [71:0]  mask;
    logic [575:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [575:0] fill(input logic [7:0] b);
    return {72{b}};
  endfunction

  function automatic vec_t mk(input string n, input logic [2:0] c, input logic [27:0] a,
                              input logic [7:0] fb, input logic [71:0] m, input logic [575:0] e);
    vec_t v;
    v.nm = n; v.cmd = c; v.addr = a; v.data = fill(fb); v.mask = m; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, input bit with_data,
                          input logic [575:0] d, input logic [71:0] m);
    int n = 0;
    app_cmd = c; app_addr = a; app_en = 1'b1;
    if (with_data) begin
      wdf_data = d; wdf_mask = m; wren = 1'b1; wend = 1'b1;
    end
    while (!(app_rdy && (!with_data || wdf_rdy)) && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept_timeout", n >= 50, 0);
    tick();
    app_en = 1'b0; wren = 1'b0; wend = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [27:0] a, input logic [575:0] exp);
    int k = 0;
    bit got = 0;
    send_cmd(3'd1, a, 0, '0, '0);
    while (!got && k < 20) begin
      tick();
      k++;
      if (rd_valid) got = 1;
    end
    chk({nm, "_valid"}, got, 1);
    chk({nm, "_latency"}, k, 7);
    chk({nm, "_end"}, rd_end, rd_valid);
    chk({nm, "_data"}, rd_data, exp);
    repeat (3) tick();
  endtask

  initial begin
    int n_acc;
    int base;
    bit beat;
    bit acc_c, acc_w;

    vecs[0]  = mk("wr8",      3'd0, 28'h8,   8'h5A, 72'h0, '0);
    vecs[1]  = mk("rd8",      3'd1, 28'h8,   8'h00, 72'h0, fill(8'h5A));
    vecs[2]  = mk("wr10ff",   3'd0, 28'h10,  8'hFF, 72'h0, '0);
    vecs[3]  = mk("wr10mask", 3'd0, 28'h10,  8'h00, 72'hFFFF_FFFF_FFFF_FFFF_FE, '0);
    vecs[4]  = mk("rdmask",   3'd1, 28'h10,  8'h00, 72'h0, {{71{8'hFF}}, 8'h00});
    vecs[5]  = mk("wr0",      3'd0, 28'h0,   8'h11, 72'h0, '0);
    vecs[6]  = mk("wr800",    3'd0, 28'h800, 8'h22, 72'h0, '0);
    vecs[7]  = mk("rdalias",  3'd1, 28'h0,   8'h00, 72'h0, fill(8'h22));
    vecs[8]  = mk("rd8again", 3'd1, 28'h8,   8'h00, 72'h0, fill(8'h5A));
    vecs[9]  = mk("wrtop",    3'd0, 28'h7F8, 8'h3C, 72'h0, '0);
    vecs[10] = mk("rdtoplsb", 3'd1, 28'h7FF, 8'h00, 72'h0, fill(8'h3C));

    repeat (3) tick();
    chk("rst_calib", calib, 0);
    chk("rst_app_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", wdf_rdy, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_err", err, 3'b000);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        chk("calib_c15", calib, 0);
        chk("app_rdy_c15", app_rdy, 0);
        chk("wdf_rdy_c15", wdf_rdy, 0);
      end
      if (k == 16) begin
        chk("calib_c16", calib, 1);
        chk("app_rdy_c16", app_rdy, 1);
        chk("wdf_rdy_c16", wdf_rdy, 1);
      end
    end

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].cmd == 3'd0) begin
        send_cmd(3'd0, vecs[i].addr, 1, vecs[i].data, vecs[i].mask);
        repeat (4) tick();
      end else begin
        read_check(vecs[i].nm, vecs[i].addr, vecs[i].exp);
      end
    end

    // write command whose beat is late, with reads queued behind it
    base = vld_cnt;
    send_cmd(3'd0, 28'h18, 0, '0, '0);
    repeat (10) tick();
    chk("stall_no_valid", vld_cnt - base, 0);
    app_cmd = 3'd1; app_addr = 28'h18; app_en = 1'b1;
    n_acc = 0; beat = 0;
    for (int c = 0; c < 60 && (n_acc < 5 || !beat); c++) begin
      if (c == 8) begin
        chk("stall_accepted", n_acc, 3);
        chk("stall_app_rdy", app_rdy, 0);
        chk("stall_valids", vld_cnt - base, 0);
        wdf_data = fill(8'hA5); wdf_mask = '0; wren = 1'b1; wend = 1'b1;
      end
      acc_c = app_en && app_rdy;
      acc_w = wren && wdf_rdy;
      tick();
      if (acc_c) begin
        n_acc++;
        if (n_acc == 5) app_en = 1'b0;
      end
      if (acc_w) begin
        beat = 1; wren = 1'b0; wend = 1'b0;
      end
    end
    app_en = 1'b0; wren = 1'b0; wend = 1'b0;
    chk("stall_all_accepted", n_acc, 5);
    repeat (20) tick();
    chk("stall_valid_count", vld_cnt - base, 5);
    chk("stall_read_data", last_rd, fill(8'hA5));

    base = vld_cnt;
    send_cmd(3'd4, 28'h8, 0, '0, '0);
    repeat (15) tick();
    chk("illegal_no_valid", vld_cnt - base, 0);
    chk("illegal_err", err, 3'b001);

    wdf_data = fill(8'h77); wren = 1'b1; wend = 1'b0;
    tick();
    wren = 1'b0;
    tick();
    chk("wdf_end_err", err, 3'b011);

    base = vld_cnt;
    send_cmd(3'd1, 28'h8, 0, '0, '0);
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (12) tick();
    chk("reset_drops_read", vld_cnt - base, 0);
    chk("reset_err_clear", err, 3'b000);
    chk("reset_calib_clear", calib, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
